pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 171 +++++++++++++++++
 tb/tb_pipelined_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked carry-pipelined adder/subtractor with valid/ready handshake
// Optional feature macro: PIPELINED_ADDER_SAT_EN (signed saturation on sat=1 beats).
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] adderOut,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Reject configurations the chunked datapath cannot represent.
  generate
    if ((WIDTH % STAGES) != 0) begin : g_bad_split
      $error("pipelined_adder: WIDTH must be divisible by STAGES");
    end
    if (WIDTH < 8 || WIDTH > 64 || STAGES < 1 || STAGES > 8) begin : g_bad_range
      $error("pipelined_adder: WIDTH or STAGES out of range");
    end
  endgenerate

  // Per-stage registers. opa_q/opb_q hold the operand chunks not yet added,
  // shifted down so the next chunk to add always sits at bits [CW-1:0].
  logic             vld_q [STAGES];
  logic             cy_q  [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
`ifdef PIPELINED_ADDER_SAT_EN
  logic             sat_q [STAGES];
`else
  logic             unused_sat;
  assign unused_sat = sat;
`endif
  logic             ovf_q;
  logic             zero_q;

  // The whole pipe moves as one shift register; it freezes only when the
  // output slot is occupied and the consumer is not taking it.
  logic advance;
  assign advance  = ~vld_q[LAST] | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic             c_in;
    logic             v_in;
`ifdef PIPELINED_ADDER_SAT_EN
    logic             s_in;
`endif
    logic [CW:0]      csum;
    logic [WIDTH-1:0] raw_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1; the +1 enters as the first chunk's carry-in.
      assign a_in = in1;
      assign b_in = sub ? ~in2 : in2;
      assign r_in = '0;
      assign c_in = sub;
      assign v_in = in_valid;
`ifdef PIPELINED_ADDER_SAT_EN
      assign s_in = sat;
`endif
    end else begin : g_body
      assign a_in = opa_q[k-1];
      assign b_in = opb_q[k-1];
      assign r_in = res_q[k-1];
      assign c_in = cy_q[k-1];
      assign v_in = vld_q[k-1];
`ifdef PIPELINED_ADDER_SAT_EN
      assign s_in = sat_q[k-1];
`endif
    end

    assign csum  = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};
    assign opa_d = a_in >> CW;
    assign opb_d = b_in >> CW;

    // Splice this stage's chunk sum into the partially built result.
    always_comb begin
      raw_d = r_in;
      raw_d[k*CW +: CW] = csum[CW-1:0];
    end

    if (k == LAST) begin : g_tail
      logic ovf_d;
      logic zero_d;

      // At the last stage a_in/b_in bit CW-1 are the original operand sign bits.
      assign ovf_d = (a_in[CW-1] == b_in[CW-1]) && (raw_d[WIDTH-1] != a_in[CW-1]);

`ifdef PIPELINED_ADDER_SAT_EN
      // Clamp toward the sign of the operands when the beat asked for it.
      always_comb begin
        res_d = raw_d;
        if (s_in && ovf_d) begin
          res_d = a_in[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign res_d = raw_d;
`endif

      assign zero_d = (res_d == '0);

      // Result flags travel with the final result register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end else begin : g_mid
      assign res_d = raw_d;
    end

    // Stage register: valid always shifts (bubbles included), data only with a real beat.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
`ifdef PIPELINED_ADDER_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end else if (advance) begin
        vld_q[k] <= v_in;
        if (v_in) begin
          cy_q[k]  <= csum[CW];
          opa_q[k] <= opa_d;
          opb_q[k] <= opb_d;
          res_q[k] <= res_d;
`ifdef PIPELINED_ADDER_SAT_EN
          sat_q[k] <= s_in;
`endif
        end
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign adderOut  = res_q[LAST];
  assign carry     = cy_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=2)
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] adderOut;
  logic        carry;
  logic        overflow;
  logic        zero;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sb;
    logic        st;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .adderOut  (adderOut),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    tick; tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (adderOut !== 32'h0) begin miscompares++; $display("FAIL reset_adderOut: got %h expected 00000000", adderOut); end
    vectors++; if ({carry, overflow, zero} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {carry, overflow, zero}); end
    reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tick;
  endtask

  task automatic test_arith;
    vec_t tbl[10];
    tbl[0] = '{a:32'h0000FFFF, b:32'h00000001, sb:1'b0, st:1'b0, r:32'h00010000, c:1'b0, v:1'b0, z:1'b0};
    tbl[1] = '{a:32'h00000005, b:32'h00000005, sb:1'b1, st:1'b0, r:32'h00000000, c:1'b1, v:1'b0, z:1'b1};
    tbl[2] = '{a:32'h00000003, b:32'h00000005, sb:1'b1, st:1'b0, r:32'hFFFFFFFE, c:1'b0, v:1'b0, z:1'b0};
    tbl[3] = '{a:32'hFFFFFFFF, b:32'h00000001, sb:1'b0, st:1'b0, r:32'h00000000, c:1'b1, v:1'b0, z:1'b1};
    tbl[4] = '{a:32'h7FFFFFFF, b:32'h00000001, sb:1'b0, st:1'b0, r:32'h80000000, c:1'b0, v:1'b1, z:1'b0};
    tbl[5] = '{a:32'h7FFFFFFF, b:32'h00000001, sb:1'b0, st:1'b1,
               r:(SAT_ON ? 32'h7FFFFFFF : 32'h80000000), c:1'b0, v:1'b1, z:1'b0};
    tbl[6] = '{a:32'h80000000, b:32'h00000001, sb:1'b1, st:1'b1,
               r:(SAT_ON ? 32'h80000000 : 32'h7FFFFFFF), c:1'b1, v:1'b1, z:1'b0};
    tbl[7] = '{a:32'h80000000, b:32'h80000000, sb:1'b0, st:1'b1,
               r:(SAT_ON ? 32'h80000000 : 32'h00000000), c:1'b1, v:1'b1, z:(SAT_ON ? 1'b0 : 1'b1)};
    tbl[8] = '{a:32'h12345678, b:32'h12345679, sb:1'b1, st:1'b0, r:32'hFFFFFFFF, c:1'b0, v:1'b0, z:1'b0};
    tbl[9] = '{a:32'hFFFF0000, b:32'h0000FFFF, sb:1'b0, st:1'b0, r:32'hFFFFFFFF, c:1'b0, v:1'b0, z:1'b0};
    out_ready = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      if (j < 10) begin
        in_valid = 1'b1; in1 = tbl[j].a; in2 = tbl[j].b; sub = tbl[j].sb; sat = tbl[j].st;
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (j == 0) begin
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: out_valid got %b expected 0", out_valid); end
      end else begin
        vectors++;
        if ({out_valid, adderOut, carry, overflow, zero} !== {1'b1, tbl[j-1].r, tbl[j-1].c, tbl[j-1].v, tbl[j-1].z}) begin
          miscompares++;
          $display("FAIL arith_vec%0d: got v=%b r=%h c=%b o=%b z=%b expected v=1 r=%h c=%b o=%b z=%b", j-1,
                   out_valid, adderOut, carry, overflow, zero, tbl[j-1].r, tbl[j-1].c, tbl[j-1].v, tbl[j-1].z);
        end
      end
    end
    sat = 1'b0; sub = 1'b0;
    tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arith_drain: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int          sent = 0;
    int          got = 0;
    int          stalls = 0;
    logic        acc;
    logic        held_v = 1'b0;
    logic [31:0] held = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      in1 = 32'h00FFFF00 + sent; in2 = 32'h00000100; sub = 1'b0; sat = 1'b0;
      #1;
      if (held_v) begin
        vectors++;
        if (adderOut !== held) begin miscompares++; $display("FAIL stall_hold: got %h expected %h", adderOut, held); end
      end
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b expected 0 at cycle %0d", in_ready, c); end
        stalls++; held = adderOut; held_v = 1'b1;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (adderOut !== 32'h01000000 + got) begin
          miscompares++; $display("FAIL stream_beat%0d: got %h expected %h", got, adderOut, 32'h01000000 + got);
        end
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    vectors++; if (got !== 8) begin miscompares++; $display("FAIL stream_count: got %0d results expected 8", got); end
    vectors++; if (stalls !== 4) begin miscompares++; $display("FAIL stream_stalls: got %0d stalled cycles expected 4", stalls); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_dup: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1; sub = 1'b0; sat = 1'b0;
    in_valid = 1'b1; in1 = 32'h7FFFFFFF; in2 = 32'h00000001;
    tick;
    in1 = 32'hFFFFFFFF; in2 = 32'h00000001;
    tick;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, adderOut, overflow} !== {1'b1, 32'h80000000, 1'b1}) begin
      miscompares++; $display("FAIL midflight_pre: got v=%b r=%h o=%b expected v=1 r=80000000 o=1", out_valid, adderOut, overflow);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
    vectors++; if (adderOut !== 32'h0) begin miscompares++; $display("FAIL async_adderOut: got %h expected 00000000", adderOut); end
    vectors++; if ({carry, overflow, zero} !== 3'b000) begin miscompares++; $display("FAIL async_flags: got %b expected 000", {carry, overflow, zero}); end
    tick;
    reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stale_result: cycle %0d out_valid got %b expected 0 (r=%h)", i, out_valid, adderOut); end
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_back_to_back;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
